etc2_block_fetch: RTL and testbench

//  Block source feeding mode_detect: reads compressed ETC2 texture data from a 32-bit

---
 rtl/etc2_block_fetch.sv | 138 +++++++++++++
 tb/tb_etc2_block_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etc2_block_fetch.sv
// rtl/etc2_block_fetch.sv - ETC2 block fetcher: 32-bit memory reads assembled into tagged 64-bit blocks
module etc2_block_fetch #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 10
) (
  input  logic              sclk,
  input  logic              rsrt,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  blocks_w,
  input  logic [DIM_W-1:0]  blocks_h,
  input  logic              punch,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [63:0]       block,
  output logic              flags,
  output logic [DIM_W-1:0]  blk_x,
  output logic [DIM_W-1:0]  blk_y,
  output logic              blk_rts,
  input  logic              blk_rtr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_HI,
    S_WAIT_HI,
    S_REQ_LO,
    S_WAIT_LO,
    S_LOAD,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  // Frame parameters captured at start
  logic [DIM_W-1:0] w_r, h_r;
  logic             punch_r;

  // Assembly slot A: data plus the coordinates of the block being fetched
  logic [63:0]      a_data;
  logic [DIM_W-1:0] cx, cy;

  logic zero_dim;
  logic last_blk;
  logic o_free;
  logic xfer;

  assign zero_dim = (blocks_w == '0) || (blocks_h == '0);
  assign last_blk = (cx == w_r - DIM_W'(1)) && (cy == h_r - DIM_W'(1));
  assign xfer     = blk_rts & blk_rtr;
  // O can accept A when empty or when its current block leaves this cycle
  assign o_free   = !blk_rts || blk_rtr;

  assign mem_rd = (state == S_REQ_HI) || (state == S_REQ_LO);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);

  // State register
  always_ff @(posedge sclk or negedge rsrt) begin
    if (!rsrt) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one outstanding read, A handed to O when O is free
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = zero_dim ? S_FIN : S_REQ_HI;
      S_REQ_HI:  state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (mem_rvalid) state_nxt = S_REQ_LO;
      S_REQ_LO:  state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (mem_rvalid) state_nxt = S_LOAD;
      S_LOAD:    if (o_free) state_nxt = last_blk ? S_DRAIN : S_REQ_HI;
      S_DRAIN:   if (o_free) state_nxt = S_FIN;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: frame capture, address walk, A assembly, O load and release
  always_ff @(posedge sclk or negedge rsrt) begin
    if (!rsrt) begin
      w_r      <= '0;
      h_r      <= '0;
      punch_r  <= 1'b0;
      a_data   <= '0;
      cx       <= '0;
      cy       <= '0;
      mem_addr <= '0;
      block    <= '0;
      flags    <= 1'b0;
      blk_x    <= '0;
      blk_y    <= '0;
      blk_rts  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        w_r      <= blocks_w;
        h_r      <= blocks_h;
        punch_r  <= punch;
        cx       <= '0;
        cy       <= '0;
        mem_addr <= base_addr;
      end

      // Raster order makes the address a plain +4 walk; wraps modulo 2^ADDR_W
      if (state == S_WAIT_HI && mem_rvalid) begin
        a_data[63:32] <= mem_rdata;
        mem_addr      <= mem_addr + ADDR_W'(4);
      end
      if (state == S_WAIT_LO && mem_rvalid) begin
        a_data[31:0] <= mem_rdata;
        mem_addr     <= mem_addr + ADDR_W'(4);
      end

      if (state == S_LOAD && o_free) begin
        block   <= a_data;
        flags   <= punch_r;
        blk_x   <= cx;
        blk_y   <= cy;
        blk_rts <= 1'b1;
        if (cx == w_r - DIM_W'(1)) begin
          cx <= '0;
          cy <= cy + DIM_W'(1);
        end else begin
          cx <= cx + DIM_W'(1);
        end
      end else if (xfer) begin
        blk_rts <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_etc2_block_fetch.sv
// tb/tb_etc2_block_fetch.sv - self-checking bench for etc2_block_fetch
module tb_etc2_block_fetch;

  logic        sclk;
  logic        rsrt;
  logic        start;
  logic [31:0] base_addr;
  logic [9:0]  blocks_w, blocks_h;
  logic        punch;
  logic        busy, done, mem_rd;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [63:0] block;
  logic        flags;
  logic [9:0]  blk_x, blk_y;
  logic        blk_rts;
  logic        blk_rtr;

  etc2_block_fetch #(.ADDR_W(32), .DIM_W(10)) dut (
    .sclk(sclk), .rsrt(rsrt), .start(start), .base_addr(base_addr),
    .blocks_w(blocks_w), .blocks_h(blocks_h), .punch(punch),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .block(block), .flags(flags), .blk_x(blk_x), .blk_y(blk_y),
    .blk_rts(blk_rts), .blk_rtr(blk_rtr)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;

  int lat_min = 1, lat_max = 1;
  int rtr_mode = 0;
  int rd_count = 0, xfer_count = 0, done_count = 0;

  logic [31:0]  exp_addr[$];
  logic [63:0]  exp_blk[$];
  logic [20:0]  exp_tag[$];
  logic [31:0]  addr_log[$];
  logic [19:0]  xy_log[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h5f91045b;
    if (a == 32'h104) return 32'h86f674a5;
    return (a * 32'h9E3779B1) ^ 32'h7F4A7C15;
  endfunction

  // Expected reads and blocks for a frame, straight from raster order
  task automatic frame_model(input logic [31:0] b, input int w, input int h, input logic p);
    for (int n = 0; n < w * h; n++) begin
      logic [31:0] a;
      logic [9:0]  x, y;
      a = b + 32'(8 * n);
      x = 10'(n % w);
      y = 10'(n / w);
      exp_addr.push_back(a);
      exp_addr.push_back(a + 32'd4);
      exp_blk.push_back({mem_word(a), mem_word(a + 32'd4)});
      exp_tag.push_back({p, x, y});
    end
  endtask

  // Memory responder: latency lat_min..lat_max, survives DUT reset on purpose
  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 0; cnt = 0; paddr = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge sclk);
      mem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(paddr);
          pend = 0;
        end
      end
      if (rsrt && mem_rd) begin
        chk("one_outstanding", 128'(pend), 128'd0);
        pend  = 1;
        paddr = mem_addr;
        cnt   = int'($urandom_range(lat_max, lat_min));
        rd_count++;
      end
    end
  end

  // Downstream ready driver
  initial begin
    blk_rtr = 1'b1;
    forever begin
      @(posedge sclk);
      #2;
      case (rtr_mode)
        0:       blk_rtr = 1'b1;
        1:       blk_rtr = 1'b0;
        default: blk_rtr = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Compare process: addresses, transfers against the model, O stability
  initial begin
    bit           prev_hold;
    logic [85:0]  prev_o;
    prev_hold = 0;
    prev_o = '0;
    forever begin
      @(negedge sclk);
      if (!rsrt) begin
        prev_hold = 0;
      end else begin
        if (mem_rd) begin
          addr_log.push_back(mem_addr);
          if (exp_addr.size() == 0) chk("unexpected_read", 128'(mem_addr), 128'hffffffff_ffffffff);
          else chk("mem_addr", 128'(mem_addr), 128'(exp_addr.pop_front()));
        end
        if (prev_hold) chk("o_stable", 128'({blk_rts, block, flags, blk_x, blk_y}), 128'(prev_o));
        if (blk_rts && blk_rtr) begin
          xfer_count++;
          xy_log.push_back({blk_x, blk_y});
          if (exp_blk.size() == 0) chk("extra_block", 128'(block), 128'hdead);
          else begin
            chk("block", 128'(block), 128'(exp_blk.pop_front()));
            chk("tag", 128'({flags, blk_x, blk_y}), 128'(exp_tag.pop_front()));
          end
        end
        if (done) done_count++;
        prev_hold = blk_rts && !blk_rtr;
        prev_o = {blk_rts, block, flags, blk_x, blk_y};
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input int w, input int h, input logic p, input bit model);
    @(posedge sclk);
    #2;
    base_addr = b;
    blocks_w  = 10'(w);
    blocks_h  = 10'(h);
    punch     = p;
    start     = 1'b1;
    if (model) frame_model(b, w, h, p);
    @(posedge sclk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit start_on_done);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sclk);
      if (done) begin
        seen = 1;
        if (start_on_done) start = 1'b1;
      end
    end
    if (!seen) chk("done_timeout", 128'd0, 128'd1);
    if (start_on_done && seen) begin
      @(posedge sclk);
      #2;
      start = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, x0, d0;
    logic s_rd[9], s_rts[9], s_done[9], s_busy[9];
    logic [63:0] s_blk6;
    logic [9:0] ex[6];
    logic [9:0] ey[6];
    ex = '{10'd0, 10'd1, 10'd2, 10'd0, 10'd1, 10'd2};
    ey = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd1};

    rsrt = 1'b0; start = 1'b0; base_addr = 0; blocks_w = 0; blocks_h = 0; punch = 0;
    repeat (3) @(posedge sclk);
    #2 rsrt = 1'b1;
    @(negedge sclk);
    chk("reset_outputs", 128'({busy, done, mem_rd, mem_addr, block, flags, blk_x, blk_y, blk_rts}), 128'd0);

    // 1x1 frame with literal latency and data
    lat_min = 1; lat_max = 1; rtr_mode = 0;
    d0 = done_count;
    do_start(32'h100, 1, 1, 1'b0, 1);
    s_blk6 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sclk);
      s_rd[k] = mem_rd; s_rts[k] = blk_rts; s_done[k] = done; s_busy[k] = busy;
      if (k == 6) s_blk6 = block;
    end
    chk("lat_busy_c1", 128'(s_busy[1]), 128'd1);
    chk("lat_rd_c1", 128'(s_rd[1]), 128'd1);
    chk("lat_rd_c2", 128'(s_rd[2]), 128'd0);
    chk("lat_rd_c3", 128'(s_rd[3]), 128'd1);
    chk("lat_rts_c5", 128'(s_rts[5]), 128'd0);
    chk("lat_rts_c6", 128'(s_rts[6]), 128'd1);
    chk("blk_1x1", 128'(s_blk6), 128'(64'h5f91045b86f674a5));
    chk("done_c7", 128'(s_done[7]), 128'd1);
    chk("busy_c8", 128'(s_busy[8]), 128'd0);
    chk("done_cnt_1x1", 128'(done_count - d0), 128'd1);

    // 3x2 raster frame, then start on the done cycle must be ignored
    addr_log.delete(); xy_log.delete();
    x0 = xfer_count; d0 = done_count;
    do_start(32'h1000, 3, 2, 1'b0, 1);
    wait_done(500, 1);
    chk("xfer_3x2", 128'(xfer_count - x0), 128'd6);
    chk("addr_cnt_3x2", 128'(addr_log.size()), 128'd12);
    if (addr_log.size() == 12) begin
      chk("addr_1_3x2", 128'(addr_log[1]), 128'(32'h1004));
      chk("addr_11_3x2", 128'(addr_log[11]), 128'(32'h102C));
    end
    if (xy_log.size() == 6)
      for (int i = 0; i < 6; i++) chk("xy_order", 128'(xy_log[i]), 128'({ex[i], ey[i]}));
    rd0 = rd_count;
    repeat (6) @(negedge sclk);
    chk("start_on_done_rd", 128'(rd_count - rd0), 128'd0);
    chk("start_on_done_busy", 128'(busy), 128'd0);
    chk("done_cnt_3x2", 128'(done_count - d0), 128'd1);

    // Backpressure with an ignored start mid-frame
    rtr_mode = 1;
    x0 = xfer_count; d0 = done_count; rd0 = rd_count;
    do_start(32'h4000, 3, 2, 1'b0, 1);
    repeat (5) @(negedge sclk);
    do_start(32'h9000, 1, 1, 1'b0, 0);
    repeat (13) @(negedge sclk);
    chk("bp_reads", 128'(rd_count - rd0), 128'd4);
    chk("bp_rts_x", 128'({blk_rts, blk_x, blk_y}), 128'({1'b1, 10'd0, 10'd0}));
    chk("bp_block", 128'(block), 128'({mem_word(32'h4000), mem_word(32'h4004)}));
    rtr_mode = 0;
    wait_done(500, 0);
    chk("bp_xfer", 128'(xfer_count - x0), 128'd6);
    chk("bp_done", 128'(done_count - d0), 128'd1);
    chk("bp_left", 128'(exp_blk.size()), 128'd0);

    // Empty frame
    rd0 = rd_count;
    do_start(32'h5000, 0, 3, 1'b0, 1);
    @(negedge sclk);
    chk("empty_c1", 128'({done, busy}), 128'b11);
    @(negedge sclk);
    chk("empty_c2", 128'({done, busy}), 128'b00);
    chk("empty_rd", 128'(rd_count - rd0), 128'd0);

    // Reset while waiting for the low word, response arrives after reset
    lat_min = 4; lat_max = 4;
    do_start(32'h2000, 2, 2, 1'b0, 1);
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge sclk);
        if (mem_rd && mem_addr == 32'h2004) found = 1;
      end
      chk("found_lo_req", 128'(found), 128'd1);
    end
    @(posedge sclk);
    #1 rsrt = 1'b0;
    @(negedge sclk);
    chk("midreset_outputs", 128'({busy, done, mem_rd, mem_addr, block, flags, blk_x, blk_y, blk_rts}), 128'd0);
    exp_addr.delete(); exp_blk.delete(); exp_tag.delete();
    @(posedge sclk);
    #2 rsrt = 1'b1;
    rd0 = rd_count;
    repeat (8) @(negedge sclk);
    chk("late_rvalid_ignored", 128'({rd_count - rd0, busy, blk_rts}), 128'd0);
    lat_min = 1; lat_max = 1;
    addr_log.delete();
    do_start(32'h3000, 1, 1, 1'b0, 1);
    wait_done(100, 0);
    chk("rst_addr_cnt", 128'(addr_log.size()), 128'd2);
    if (addr_log.size() >= 1) chk("rst_addr0", 128'(addr_log[0]), 128'(32'h3000));

    // Random latency and ready, punch-through, address wrap
    lat_min = 1; lat_max = 8; rtr_mode = 2;
    addr_log.delete();
    x0 = xfer_count;
    do_start(32'hFFFFFFF8, 3, 2, 1'b1, 1);
    wait_done(3000, 0);
    rtr_mode = 0;
    chk("rnd_xfer", 128'(xfer_count - x0), 128'd6);
    if (addr_log.size() >= 3) chk("wrap_addr", 128'(addr_log[2]), 128'd0);
    chk("rnd_left", 128'(exp_blk.size() + exp_addr.size()), 128'd0);

    repeat (3) @(negedge sclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
